// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the unified program/data RAM arbiter.
package mem_arbiter_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;

   localparam logic [BE_W-1:0] BE_FULL = 4'hF;

   typedef enum logic [0:0] {
      ST_IDLE,
      ST_RMW_WR
   } state_e;

   // Per-lane select: enabled lanes come from the new data, the rest from the old word.
   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [BE_W-1:0]   be,
      input logic [DATA_W-1:0] new_word,
      input logic [DATA_W-1:0] old_word
   );
      logic [DATA_W-1:0] res;
      res = old_word;
      for (int i = 0; i < int'(BE_W); i++) begin
         if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_byte_merge.sv
// Combinational byte-lane merge for read-modify-write stores.
module mem_byte_merge
   import mem_arbiter_pkg::*;
(
   input  logic [BE_W-1:0]   be,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] merged_c
);

   always_comb begin
      merged_c = merge_bytes(be, wdata, rdata);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single-port unified RAM: loader, fetch and data ports, sub-word stores as RMW.
// Optional fetch anti-starvation enabled by defining ARB_FAIRNESS_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              boot_mode,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [BE_W-1:0]   dm_be,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic              ram_rst,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_di,
   input  logic [DATA_W-1:0] ram_dout
);

   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("STARVE_LIMIT must be at least 1");
   end

   state_e            state;
   state_e            state_nxt;
   logic              rmw_load;
   logic [ADDR_W-1:0] rmw_addr;
   logic [BE_W-1:0]   rmw_be;
   logic [DATA_W-1:0] rmw_wdata;
   logic [DATA_W-1:0] rmw_merged;
   logic              fetch_first;

   assign ram_rst  = 1'b0;
   assign if_rdata = ram_dout;
   assign dm_rdata = ram_dout;

   mem_byte_merge u_merge (
      .be       (rmw_be),
      .wdata    (rmw_wdata),
      .rdata    (ram_dout),
      .merged_c (rmw_merged)
   );

`ifdef ARB_FAIRNESS_EN
   localparam int unsigned CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;

   assign fetch_first = if_req && (starve_cnt >= CNT_W'(STARVE_LIMIT));

   // Counts consecutive IDLE run-mode cycles in which fetch wanted the RAM but lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (state == ST_IDLE && !boot_mode) begin
         if (!if_req || if_gnt) begin
            starve_cnt <= '0;
         end else if (starve_cnt < CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign fetch_first = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         rmw_addr  <= '0;
         rmw_be    <= '0;
         rmw_wdata <= '0;
      end else begin
         state     <= state_nxt;
         if_rvalid <= if_gnt;
         dm_rvalid <= dm_gnt & ~dm_we & (state == ST_IDLE);
         if (rmw_load) begin
            rmw_addr  <= dm_addr;
            rmw_be    <= dm_be;
            rmw_wdata <= dm_wdata;
         end
      end
   end

   // Grant selection and RAM port drive; everything idles while reset is held.
   always_comb begin
      state_nxt = state;
      rmw_load  = 1'b0;
      ld_ready  = 1'b0;
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_di    = '0;

      if (rst) begin
         unique case (state)
            ST_IDLE: begin
               if (boot_mode) begin
                  ld_ready = 1'b1;
                  if (ld_valid) begin
                     ram_en   = 1'b1;
                     ram_we   = 1'b1;
                     ram_addr = ld_addr;
                     ram_di   = ld_data;
                  end
               end else if (dm_req && !fetch_first) begin
                  if (!dm_we) begin
                     ram_en   = 1'b1;
                     ram_addr = dm_addr;
                     dm_gnt   = 1'b1;
                  end else if (dm_be == BE_FULL) begin
                     ram_en   = 1'b1;
                     ram_we   = 1'b1;
                     ram_addr = dm_addr;
                     ram_di   = dm_wdata;
                     dm_gnt   = 1'b1;
                  end else if (dm_be == '0) begin
                     dm_gnt   = 1'b1;
                  end else begin
                     // Sub-word store: fetch the old word now, merge and write next cycle.
                     ram_en    = 1'b1;
                     ram_addr  = dm_addr;
                     rmw_load  = 1'b1;
                     state_nxt = ST_RMW_WR;
                  end
               end else if (if_req) begin
                  ram_en   = 1'b1;
                  ram_addr = if_addr;
                  if_gnt   = 1'b1;
               end
            end
            ST_RMW_WR: begin
               ram_en    = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = rmw_addr;
               ram_di    = rmw_merged;
               dm_gnt    = 1'b1;
               state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 256-word synchronous RAM.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        boot_mode;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic        ram_en;
   logic        ram_we;
   logic        ram_rst;
   logic [31:0] ram_addr;
   logic [31:0] ram_di;
   logic [31:0] ram_dout;

   logic [31:0] mem [0:255];

   int n_cmp;
   int n_fail;

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .boot_mode (boot_mode),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_be     (dm_be),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_gnt    (dm_gnt),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_rst   (ram_rst),
      .ram_addr  (ram_addr),
      .ram_di    (ram_di),
      .ram_dout  (ram_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single-port RAM, 1-cycle read latency, index truncated to 8 bits.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr[9:2]] <= ram_di;
         else        ram_dout <= mem[ram_addr[9:2]];
      end
   end

   task automatic idle_inputs();
      boot_mode = 1'b0;
      ld_valid  = 1'b0;
      ld_addr   = '0;
      ld_data   = '0;
      if_req    = 1'b0;
      if_addr   = '0;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      dm_be     = '0;
      dm_addr   = '0;
      dm_wdata  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      if_req = 1'b1; dm_req = 1'b1; ld_valid = 1'b1;
      #1;
      n_cmp++; if (if_gnt !== 1'b0)    begin n_fail++; $display("FAIL rst_if_gnt got=%b want=0", if_gnt); end
      n_cmp++; if (dm_gnt !== 1'b0)    begin n_fail++; $display("FAIL rst_dm_gnt got=%b want=0", dm_gnt); end
      n_cmp++; if (ram_en !== 1'b0)    begin n_fail++; $display("FAIL rst_ram_en got=%b want=0", ram_en); end
      n_cmp++; if (ram_we !== 1'b0)    begin n_fail++; $display("FAIL rst_ram_we got=%b want=0", ram_we); end
      n_cmp++; if (ld_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_ld_ready got=%b want=0", ld_ready); end
      n_cmp++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_if_rvalid got=%b want=0", if_rvalid); end
      n_cmp++; if (dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_dm_rvalid got=%b want=0", dm_rvalid); end
      n_cmp++; if (ram_rst !== 1'b0)   begin n_fail++; $display("FAIL rst_ram_rst got=%b want=0", ram_rst); end
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
   endtask

   task automatic test_boot_write();
      @(negedge clk);
      boot_mode = 1'b1; ld_valid = 1'b1; ld_addr = 32'h10; ld_data = 32'hDEADBEEF;
      if_req = 1'b1; if_addr = 32'h10;
      #1;
      n_cmp++; if (ld_ready !== 1'b1)         begin n_fail++; $display("FAIL boot_ld_ready got=%b want=1", ld_ready); end
      n_cmp++; if (ram_we !== 1'b1)           begin n_fail++; $display("FAIL boot_ram_we got=%b want=1", ram_we); end
      n_cmp++; if (ram_addr !== 32'h10)       begin n_fail++; $display("FAIL boot_ram_addr got=%h want=00000010", ram_addr); end
      n_cmp++; if (ram_di !== 32'hDEADBEEF)   begin n_fail++; $display("FAIL boot_ram_di got=%h want=deadbeef", ram_di); end
      n_cmp++; if (if_gnt !== 1'b0)           begin n_fail++; $display("FAIL boot_if_gnt got=%b want=0", if_gnt); end
      @(negedge clk);
      ld_addr = 32'h20; ld_data = 32'h12345678;
      #1;
      n_cmp++; if (ram_addr !== 32'h20)       begin n_fail++; $display("FAIL boot2_ram_addr got=%h want=00000020", ram_addr); end
      @(negedge clk);
      ld_valid = 1'b0;
      #1;
      n_cmp++; if (ram_en !== 1'b0)           begin n_fail++; $display("FAIL boot_idle_ram_en got=%b want=0", ram_en); end
      n_cmp++; if (ld_ready !== 1'b1)         begin n_fail++; $display("FAIL boot_idle_ld_ready got=%b want=1", ld_ready); end
      n_cmp++; if (if_rvalid !== 1'b0)        begin n_fail++; $display("FAIL boot_if_rvalid got=%b want=0", if_rvalid); end
   endtask

   task automatic test_fetch();
      logic [31:0] addrs [3];
      addrs[0] = 32'h10; addrs[1] = 32'h13; addrs[2] = 32'h410;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle_inputs();
         if_req = 1'b1; if_addr = addrs[i];
         #1;
         n_cmp++; if (if_gnt !== 1'b1)      begin n_fail++; $display("FAIL fetch%0d_gnt got=%b want=1", i, if_gnt); end
         n_cmp++; if (ram_addr !== addrs[i]) begin n_fail++; $display("FAIL fetch%0d_addr got=%h want=%h", i, ram_addr, addrs[i]); end
         n_cmp++; if (ram_we !== 1'b0)      begin n_fail++; $display("FAIL fetch%0d_we got=%b want=0", i, ram_we); end
         @(negedge clk);
         if_req = 1'b0;
         #1;
         n_cmp++; if (if_rvalid !== 1'b1)        begin n_fail++; $display("FAIL fetch%0d_rvalid got=%b want=1", i, if_rvalid); end
         n_cmp++; if (if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch%0d_rdata got=%h want=deadbeef", i, if_rdata); end
      end
   endtask

   task automatic test_conflict();
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h10;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
      #1;
      n_cmp++; if (dm_gnt !== 1'b1)     begin n_fail++; $display("FAIL conf_dm_gnt got=%b want=1", dm_gnt); end
      n_cmp++; if (if_gnt !== 1'b0)     begin n_fail++; $display("FAIL conf_if_gnt got=%b want=0", if_gnt); end
      n_cmp++; if (ram_addr !== 32'h20) begin n_fail++; $display("FAIL conf_ram_addr got=%h want=00000020", ram_addr); end
      @(negedge clk);
      dm_req = 1'b0;
      #1;
      n_cmp++; if (if_gnt !== 1'b1)           begin n_fail++; $display("FAIL conf2_if_gnt got=%b want=1", if_gnt); end
      n_cmp++; if (dm_rvalid !== 1'b1)        begin n_fail++; $display("FAIL conf2_dm_rvalid got=%b want=1", dm_rvalid); end
      n_cmp++; if (dm_rdata !== 32'h12345678) begin n_fail++; $display("FAIL conf2_dm_rdata got=%h want=12345678", dm_rdata); end
      n_cmp++; if (if_rvalid !== 1'b0)        begin n_fail++; $display("FAIL conf2_if_rvalid got=%b want=0", if_rvalid); end
      @(negedge clk);
      if_req = 1'b0;
      #1;
      n_cmp++; if (if_rvalid !== 1'b1)        begin n_fail++; $display("FAIL conf3_if_rvalid got=%b want=1", if_rvalid); end
      n_cmp++; if (if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL conf3_if_rdata got=%h want=deadbeef", if_rdata); end
      n_cmp++; if (dm_rvalid !== 1'b0)        begin n_fail++; $display("FAIL conf3_dm_rvalid got=%b want=0", dm_rvalid); end
   endtask

   task automatic test_partial_store();
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0010; dm_addr = 32'h10; dm_wdata = 32'h0000AA00;
      if_req = 1'b1; if_addr = 32'h20;
      #1;
      n_cmp++; if (dm_gnt !== 1'b0)     begin n_fail++; $display("FAIL rmw_rd_dm_gnt got=%b want=0", dm_gnt); end
      n_cmp++; if (if_gnt !== 1'b0)     begin n_fail++; $display("FAIL rmw_rd_if_gnt got=%b want=0", if_gnt); end
      n_cmp++; if (ram_en !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rmw_rd_en_we got=%b%b want=10", ram_en, ram_we); end
      n_cmp++; if (ram_addr !== 32'h10) begin n_fail++; $display("FAIL rmw_rd_addr got=%h want=00000010", ram_addr); end
      @(negedge clk);
      #1;
      n_cmp++; if (dm_gnt !== 1'b1)         begin n_fail++; $display("FAIL rmw_wr_dm_gnt got=%b want=1", dm_gnt); end
      n_cmp++; if (if_gnt !== 1'b0)         begin n_fail++; $display("FAIL rmw_wr_if_gnt got=%b want=0", if_gnt); end
      n_cmp++; if (ram_we !== 1'b1)         begin n_fail++; $display("FAIL rmw_wr_we got=%b want=1", ram_we); end
      n_cmp++; if (ram_addr !== 32'h10)     begin n_fail++; $display("FAIL rmw_wr_addr got=%h want=00000010", ram_addr); end
      n_cmp++; if (ram_di !== 32'hDEADAAEF) begin n_fail++; $display("FAIL rmw_wr_di got=%h want=deadaaef", ram_di); end
      @(negedge clk);
      dm_req = 1'b0; if_addr = 32'h10;
      #1;
      n_cmp++; if (if_gnt !== 1'b1)         begin n_fail++; $display("FAIL rmw_after_if_gnt got=%b want=1", if_gnt); end
      n_cmp++; if (dm_rvalid !== 1'b0)      begin n_fail++; $display("FAIL rmw_dm_rvalid got=%b want=0", dm_rvalid); end
      @(negedge clk);
      if_req = 1'b0;
      #1;
      n_cmp++; if (if_rdata !== 32'hDEADAAEF || if_rvalid !== 1'b1) begin n_fail++; $display("FAIL rmw_readback got=%h/%b want=deadaaef/1", if_rdata, if_rvalid); end
   endtask

   task automatic test_full_and_empty_store();
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h20; dm_wdata = 32'hCAFEF00D;
      #1;
      n_cmp++; if (dm_gnt !== 1'b1 || ram_we !== 1'b1) begin n_fail++; $display("FAIL full_gnt_we got=%b%b want=11", dm_gnt, ram_we); end
      n_cmp++; if (ram_di !== 32'hCAFEF00D)            begin n_fail++; $display("FAIL full_di got=%h want=cafef00d", ram_di); end
      @(negedge clk);
      dm_be = 4'h0; dm_wdata = 32'h0;
      #1;
      n_cmp++; if (dm_gnt !== 1'b1) begin n_fail++; $display("FAIL empty_gnt got=%b want=1", dm_gnt); end
      n_cmp++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL empty_ram_en got=%b want=0", ram_en); end
      @(negedge clk);
      dm_we = 1'b0;
      #1;
      n_cmp++; if (dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL store_dm_rvalid got=%b want=0", dm_rvalid); end
      @(negedge clk);
      dm_req = 1'b0;
      #1;
      n_cmp++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL full_readback got=%h/%b want=cafef00d/1", dm_rdata, dm_rvalid); end
   endtask

   task automatic test_reset_rmw();
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0001; dm_addr = 32'h20; dm_wdata = 32'h000000FF;
      #1;
      n_cmp++; if (dm_gnt !== 1'b0) begin n_fail++; $display("FAIL rrmw_rd_gnt got=%b want=0", dm_gnt); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rrmw_ram got=%b%b want=00", ram_en, ram_we); end
      n_cmp++; if (dm_gnt !== 1'b0)    begin n_fail++; $display("FAIL rrmw_gnt got=%b want=0", dm_gnt); end
      n_cmp++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL rrmw_rvalid got=%b%b want=00", if_rvalid, dm_rvalid); end
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      if_req = 1'b1; if_addr = 32'h20;
      #1;
      n_cmp++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rrmw_idle_if_gnt got=%b want=1", if_gnt); end
      @(negedge clk);
      if_req = 1'b0;
      #1;
      n_cmp++; if (if_rdata !== 32'hCAFEF00D || if_rvalid !== 1'b1) begin n_fail++; $display("FAIL rrmw_word got=%h/%b want=cafef00d/1", if_rdata, if_rvalid); end
   endtask

   task automatic test_back_to_back();
      logic prev_if;
      logic prev_dm;
      logic exp_if;
      prev_if = 1'b0;
      prev_dm = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10;
         if_req = 1'b1; if_addr = 32'h20;
         #1;
`ifdef ARB_FAIRNESS_EN
         exp_if = (i == 4);
`else
         exp_if = 1'b0;
`endif
         n_cmp++; if (if_gnt !== exp_if)  begin n_fail++; $display("FAIL b2b%0d_if_gnt got=%b want=%b", i, if_gnt, exp_if); end
         n_cmp++; if (dm_gnt !== !exp_if) begin n_fail++; $display("FAIL b2b%0d_dm_gnt got=%b want=%b", i, dm_gnt, !exp_if); end
         n_cmp++; if (dm_rvalid !== prev_dm || if_rvalid !== prev_if) begin n_fail++; $display("FAIL b2b%0d_rvalid got=%b%b want=%b%b", i, dm_rvalid, if_rvalid, prev_dm, prev_if); end
         if (prev_dm) begin
            n_cmp++; if (dm_rdata !== 32'hDEADAAEF) begin n_fail++; $display("FAIL b2b%0d_dm_rdata got=%h want=deadaaef", i, dm_rdata); end
         end
         if (prev_if) begin
            n_cmp++; if (if_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b%0d_if_rdata got=%h want=cafef00d", i, if_rdata); end
         end
         prev_if = exp_if;
         prev_dm = !exp_if;
      end
      @(negedge clk);
      idle_inputs();
      #1;
      n_cmp++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hDEADAAEF) begin n_fail++; $display("FAIL b2b_last got=%h/%b want=deadaaef/1", dm_rdata, dm_rvalid); end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_boot_write();
      test_fetch();
      test_conflict();
      test_partial_store();
      test_full_and_empty_store();
      test_reset_rmw();
      test_back_to_back();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
